audio_sample_out: RTL and testbench

AUDIO_SAMPLE_OUT -- requirements
Module: audio_sample_out

---
 rtl/audio_sample_out.sv | 143 ++++++++++++++
 tb/tb_audio_sample_out.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_out.sv
// audio_sample_out: decimates the drum-centre displacement, applies gain with
// saturation, and streams stereo 16-bit words through a first-word-fall-through FIFO.
module audio_sample_out #(
  parameter int DECIM      = 1,
  parameter int GAIN_SHIFT = 2,
  parameter int DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] u_center,
  input  logic        step_valid,
  input  logic        audio_ready,
  output logic [31:0] audio_data,
  output logic        audio_valid,
  output logic [4:0]  fifo_count,
  output logic [7:0]  overflow_cnt,
  output logic        sat_flag
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = 18 + GAIN_SHIFT;
  localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);
  localparam logic [4:0] FULL_COUNT = 5'(DEPTH);
  localparam logic signed [SW-1:0] SAT_MAX = SW'(32'sd131071);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-32'sd131072);

  function automatic logic signed [SW-1:0] scale(input logic [17:0] u);
    logic signed [SW-1:0] ext;
    ext = SW'($signed(u));
    return ext <<< GAIN_SHIFT;
  endfunction

  function automatic logic clamps(input logic signed [SW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  // Clamp to signed 18-bit, then keep bits [17:2] (truncation, no rounding).
  function automatic logic [15:0] to_sample16(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] c;
    if (v > SAT_MAX) begin
      c = SAT_MAX;
    end else if (v < SAT_MIN) begin
      c = SAT_MIN;
    end else begin
      c = v;
    end
    return 16'(c >>> 2);
  endfunction

  logic [7:0]          dec_cnt;
  logic                s1_valid;
  logic [17:0]         s1_data;
  logic [31:0]         mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  logic                capture;
  logic signed [SW-1:0] scaled;
  logic                clip;
  logic [15:0]         sample16;
  logic [31:0]         word;
  logic                pop;
  logic                push;
  logic                drop;
  logic [4:0]          next_count;
  logic [AW-1:0]       next_rd;
  logic [31:0]         next_data;

  // Stage-2 formatting and FIFO next-state; next_data is the head after this edge.
  always_comb begin
    capture  = step_valid && (dec_cnt == DECIM_LAST);
    scaled   = scale(s1_data);
    clip     = s1_valid && clamps(scaled);
    sample16 = to_sample16(scaled);
    word     = {sample16, sample16};
    pop      = audio_valid && audio_ready;
    if (fifo_count == FULL_COUNT) begin
      push = s1_valid && pop;
      drop = s1_valid && !pop;
    end else begin
      push = s1_valid;
      drop = 1'b0;
    end
    next_count = fifo_count + {4'd0, push} - {4'd0, pop};
    next_rd    = rd_ptr + AW'(pop);
    if (next_count == 5'd0) begin
      next_data = 32'd0;
    end else if (push && (next_rd == wr_ptr)) begin
      next_data = word;
    end else begin
      next_data = mem[next_rd];
    end
  end

  // Control state, pipeline valid and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      dec_cnt      <= 8'd0;
      s1_valid     <= 1'b0;
      s1_data      <= 18'd0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= 5'd0;
      overflow_cnt <= 8'd0;
      sat_flag     <= 1'b0;
      audio_valid  <= 1'b0;
      audio_data   <= 32'd0;
    end else begin
      if (step_valid) begin
        if (dec_cnt == DECIM_LAST) begin
          dec_cnt <= 8'd0;
        end else begin
          dec_cnt <= dec_cnt + 8'd1;
        end
      end
      s1_valid <= capture;
      if (capture) begin
        s1_data <= u_center;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1'b1);
      end
      rd_ptr     <= next_rd;
      fifo_count <= next_count;
      if (drop && (overflow_cnt != 8'hFF)) begin
        overflow_cnt <= overflow_cnt + 8'd1;
      end
      if (clip) begin
        sat_flag <= 1'b1;
      end
      audio_valid <= (next_count != 5'd0);
      audio_data  <= next_data;
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr] <= word;
    end
  end

endmodule

// File: tb/tb_audio_sample_out.sv
// Bench for audio_sample_out: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal words.
module tb_audio_sample_out;

  localparam int DEPTH = 4;
  localparam int GS    = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] u_center;
  logic        step_valid;
  logic        audio_ready;
  logic [31:0] audio_data;
  logic        audio_valid;
  logic [4:0]  fifo_count;
  logic [7:0]  overflow_cnt;
  logic        sat_flag;

  logic [17:0] u_center2;
  logic        step_valid2;
  logic        audio_ready2;
  logic [31:0] audio_data2;
  logic        audio_valid2;
  logic [4:0]  fifo_count2;
  logic [7:0]  overflow_cnt2;
  logic        sat_flag2;

  always #5 clock = ~clock;

  audio_sample_out #(.DECIM(1), .GAIN_SHIFT(GS), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .u_center(u_center), .step_valid(step_valid),
    .audio_ready(audio_ready), .audio_data(audio_data), .audio_valid(audio_valid),
    .fifo_count(fifo_count), .overflow_cnt(overflow_cnt), .sat_flag(sat_flag)
  );

  audio_sample_out #(.DECIM(3), .GAIN_SHIFT(GS), .DEPTH(DEPTH)) dut_dec (
    .clock(clock), .reset(reset), .u_center(u_center2), .step_valid(step_valid2),
    .audio_ready(audio_ready2), .audio_data(audio_data2), .audio_valid(audio_valid2),
    .fifo_count(fifo_count2), .overflow_cnt(overflow_cnt2), .sat_flag(sat_flag2)
  );

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Reference model: captured samples land in a bounded queue one edge later.
  logic [31:0] m_q[$];
  logic        m_pend_v = 1'b0;
  logic [17:0] m_pend_u = 18'd0;
  int          m_ovf    = 0;
  logic        m_sat    = 1'b0;
  int          mv;
  logic [15:0] mh;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_q.delete();
        m_pend_v = 1'b0;
        m_ovf    = 0;
        m_sat    = 1'b0;
      end else begin
        if (m_q.size() != 0 && audio_ready) void'(m_q.pop_front());
        if (m_pend_v) begin
          mv = int'($signed(m_pend_u)) * (1 << GS);
          if (mv > 131071) begin
            mv = 131071;
            m_sat = 1'b1;
          end else if (mv < -131072) begin
            mv = -131072;
            m_sat = 1'b1;
          end
          mh = 16'(mv / 4 - ((mv < 0 && (mv % 4) != 0) ? 1 : 0));
          if (m_q.size() < DEPTH) m_q.push_back({mh, mh});
          else if (m_ovf < 255) m_ovf++;
        end
        m_pend_v = step_valid;
        m_pend_u = u_center;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("m_valid", {31'd0, audio_valid}, {31'd0, m_q.size() != 0});
        chk("m_data", audio_data, (m_q.size() != 0) ? m_q[0] : 32'd0);
        chk("m_count", {27'd0, fifo_count}, 32'(m_q.size()));
        chk("m_ovf", {24'd0, overflow_cnt}, 32'(m_ovf));
        chk("m_sat", {31'd0, sat_flag}, {31'd0, m_sat});
      end
    end
  end

  logic [31:0] d2q[$];
  initial begin
    forever begin
      @(negedge clock);
      if (audio_valid2 === 1'b1) d2q.push_back(audio_data2);
    end
  end

  logic [31:0] dec_exp [3];

  initial begin
    dec_exp[0] = 32'h0003_0003;
    dec_exp[1] = 32'h0006_0006;
    dec_exp[2] = 32'h0009_0009;
    reset = 1'b1; u_center = 18'd0; step_valid = 1'b0; audio_ready = 1'b0;
    u_center2 = 18'd0; step_valid2 = 1'b0; audio_ready2 = 1'b1;
    repeat (3) cyc();
    chk("rst_valid", {31'd0, audio_valid}, 32'd0);
    chk("rst_data", audio_data, 32'd0);
    chk("rst_count", {27'd0, fifo_count}, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Decimation by 3: only pulses 3, 6, 9 produce words.
    for (int k = 1; k <= 9; k++) begin
      u_center2 = 18'(k); step_valid2 = 1'b1; cyc();
      step_valid2 = 1'b0; cyc();
    end
    repeat (3) cyc();
    chk("dec_nwords", 32'(d2q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("dec_word", (d2q.size() > i) ? d2q[i] : 32'hDEAD_BEEF, dec_exp[i]);
    chk("dec_count", {27'd0, fifo_count2}, 32'd0);
    chk("dec_ovf", {24'd0, overflow_cnt2}, 32'd0);
    chk("dec_sat", {31'd0, sat_flag2}, 32'd0);

    // Conversion latency and value.
    audio_ready = 1'b1; u_center = 18'h01000; step_valid = 1'b1; cyc();
    step_valid = 1'b0;
    chk("conv_early", {31'd0, audio_valid}, 32'd0);
    cyc();
    chk("conv_valid", {31'd0, audio_valid}, 32'd1);
    chk("conv_data", audio_data, 32'h1000_1000);
    chk("conv_sat", {31'd0, sat_flag}, 32'd0);
    cyc();

    // Saturation in both directions.
    u_center = 18'h10000; step_valid = 1'b1; cyc();
    step_valid = 1'b0; cyc();
    chk("sat_pos", audio_data, 32'h7FFF_7FFF);
    chk("sat_flag1", {31'd0, sat_flag}, 32'd1);
    cyc();
    u_center = 18'h30000; step_valid = 1'b1; cyc();
    step_valid = 1'b0; cyc();
    chk("sat_neg", audio_data, 32'h8000_8000);
    repeat (3) cyc();
    chk("sat_sticky", {31'd0, sat_flag}, 32'd1);

    // Backpressure, back-to-back pulses, overflow drop.
    audio_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      u_center = 18'(k); step_valid = 1'b1; cyc();
    end
    step_valid = 1'b0; cyc(); cyc();
    chk("bp_count", {27'd0, fifo_count}, 32'd4);
    chk("bp_ovf", {24'd0, overflow_cnt}, 32'd1);
    audio_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("bp_word", audio_data, {16'(k), 16'(k)});
      cyc();
    end
    chk("bp_empty", {31'd0, audio_valid}, 32'd0);

    // Full FIFO with push and pop on the same edge.
    audio_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      u_center = 18'(k * 256); step_valid = 1'b1; cyc();
    end
    step_valid = 1'b0; cyc();
    chk("pp_full", {27'd0, fifo_count}, 32'd4);
    u_center = 18'h00500; step_valid = 1'b1; cyc();
    step_valid = 1'b0; audio_ready = 1'b1; cyc();
    chk("pp_count", {27'd0, fifo_count}, 32'd4);
    chk("pp_ovf", {24'd0, overflow_cnt}, 32'd1);
    for (int k = 2; k <= 5; k++) begin
      chk("pp_word", audio_data, {16'(k * 256), 16'(k * 256)});
      cyc();
    end
    chk("pp_empty", {31'd0, audio_valid}, 32'd0);

    // Overflow counter saturation.
    audio_ready = 1'b0; u_center = 18'd7; step_valid = 1'b1;
    repeat (300) cyc();
    step_valid = 1'b0; cyc(); cyc();
    chk("ovf_sat", {24'd0, overflow_cnt}, 32'd255);

    // Reset mid-operation: 3 entries queued, one in stage 1.
    audio_ready = 1'b1; repeat (6) cyc();
    audio_ready = 1'b0;
    chk("rm_empty", {31'd0, audio_valid}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      u_center = 18'(16 + k); step_valid = 1'b1; cyc();
    end
    u_center = 18'h00099; cyc();
    chk("rm_three", {27'd0, fifo_count}, 32'd3);
    reset = 1'b1; cyc();
    reset = 1'b0; step_valid = 1'b0;
    chk("rm_count", {27'd0, fifo_count}, 32'd0);
    chk("rm_valid", {31'd0, audio_valid}, 32'd0);
    chk("rm_ovf", {24'd0, overflow_cnt}, 32'd0);
    chk("rm_data", audio_data, 32'd0);
    audio_ready = 1'b1; repeat (5) cyc();
    chk("rm_stale", {31'd0, audio_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
